ffd_reg: RTL and testbench
==========================

# ffd_reg

Parameterizable D-type register/delay line with synchronous active-low reset. It is the basic sequential storage primitive for retiming and pipelining single-bit or bus signals across one clock domain. It is also used as the smoke-test block for the unit-test flow. Default configuration is a single 1-bit flip-flop: `q` follows `d` one clock later and is forced low by reset.

## Interface
- `WIDTH`, default 1: data width of `d` and `q`, minimum 1.
- `STAGES`, default 1: number of register stages between `d` and `q`, minimum 1.
- `RESET_VAL`, default all-zeros (`WIDTH` bits): value loaded into every stage on reset.
- `aclk` input 1: clock; all state updates on the rising edge. One clock only.
- `arstn` input 1: reset, synchronous and active-low. It is sampled on the rising `aclk` edge and has no asynchronous effect.
- `d` input `WIDTH`: data in.
- `q` output `WIDTH`: data out, driven directly from the last stage register with no combinational path from `d`.
- Port order is fixed as `aclk`, `arstn`, `d`, `q` to support positional instantiation.

## Operation
- Internal chain `stage[0..STAGES-1]`, each `WIDTH` bits wide. `q = stage[STAGES-1]`.
- Rising edge with `arstn`=0: every stage loads `RESET_VAL`, and `d` is ignored.
- Rising edge with `arstn`=1: `stage[0]` loads `d`, and `stage[i]` loads `stage[i-1]` for i ≥ 1.
- No enable, no handshake. The block shifts on every cycle.
- Reset mid-operation flushes all in-flight data at the next edge. Nothing in flight survives reset.
- After reset is released, `q` holds `RESET_VAL` until the first sampled `d` has propagated through the chain.
- Before the first rising edge with `arstn`=0, the state is undefined; X in simulation is acceptable. No initial-value assignment is used for synthesis.
- Bits are independent. There is no arithmetic and no width conversion.

## Timing
- Latency is `STAGES` rising edges from `d` to `q`. The default is 1 cycle.
- `q` changes only just after a rising `aclk` edge.
- If reset is asserted at edge N, `q` equals `RESET_VAL` after edge N. This holds for any `STAGES` value.
- If reset is deasserted at edge N, so `arstn` is sampled high at N, then `d` sampled at N appears on `q` after edge N+`STAGES`-1.
- For the default configuration, `d` sampled at edge N appears on `q` right after edge N.
- If `arstn` is low at an edge, reset wins over data at that edge.

## Configuration
- `FFD_REG_CHECK_EN` defined: simulation-only checks are compiled in.
  - Error if `d` contains X/Z at a rising edge while `arstn`=1.
  - Error if `q` differs from a behavioural shadow model of the delay line.
  - Error if `STAGES` < 1 or `WIDTH` < 1 at elaboration.
- Macro not defined: no checks are present, and the RTL is pure synthesizable flops.

## Structure
- Package `ffd_reg_pkg` holds:
  - the default constants `FFD_DEFAULT_WIDTH`=1 and `FFD_DEFAULT_STAGES`=1;
  - the check-message prefix string used by the `FFD_REG_CHECK_EN` logic.
- Sub-module `ffd_reg_stage` is a single `WIDTH`-bit register with synchronous active-low reset to `RESET_VAL`. `ffd_reg` generate-instantiates it `STAGES` times.

## Test plan
All scenarios use a 4 ns clock period: `aclk` toggles every 2 ns.

- **Reset:** `d`=0, `arstn`=0 for 100 ns, then released to 1 → `q`=0 immediately after release, with no X.
- **Data follow:** default config, after reset drive `d`=1 → `q`=1 after the next rising edge. Then `d`=0 → `q`=0 after the following edge.
- **Reset priority:** `d`=1 held, `q`=1, then assert `arstn`=0 for one edge → `q`=0 after that edge, despite `d`=1.
- **Sync-only reset:** pulse `arstn` low for 1 ns between rising edges → `q` unchanged.
- **Delay line:** `WIDTH`=8, `STAGES`=3, `RESET_VAL`=8'hA5. Drive the sequence 8'h01, 8'h02, 8'h03 after reset → `q` reads A5, A5, then 01, 02, 03 on successive edges.
- **Mid-stream reset:** same config with the pipeline full of 01/02/03 → one reset edge gives `q`=A5. All three in-flight values are discarded.

Source files
------------

// File: rtl/ffd_reg_pkg.sv
// Shared defaults and check-message prefix for the ffd_reg delay line.
// The prefix is consumed only when FFD_REG_CHECK_EN is defined.
package ffd_reg_pkg;

  localparam int FFD_DEFAULT_WIDTH  = 1;
  localparam int FFD_DEFAULT_STAGES = 1;

  localparam string FFD_CHECK_PREFIX = "[ffd_reg check]";

endpackage

// File: rtl/ffd_reg_stage.sv
// Single WIDTH-bit register stage with synchronous active-low reset to RESET_VAL.
// Optional checks in the parent are enabled by FFD_REG_CHECK_EN; this stage has none.
module ffd_reg_stage
  import ffd_reg_pkg::*;
#(
  parameter int                 WIDTH     = FFD_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic             aclk,
  input  logic             arstn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  // Reset is sampled on the edge only; no asynchronous path.
  always_ff @(posedge aclk) begin
    if (!arstn) begin
      r_q <= RESET_VAL;
    end else begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/ffd_reg.sv
// Parameterizable D-type delay line: STAGES chained ffd_reg_stage registers.
// Define FFD_REG_CHECK_EN to compile in simulation-only X, shadow-model and parameter checks.
module ffd_reg
  import ffd_reg_pkg::*;
#(
  parameter int               WIDTH     = FFD_DEFAULT_WIDTH,
  parameter int               STAGES    = FFD_DEFAULT_STAGES,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             aclk,
  input  logic             arstn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // w_chain[0] is the input; w_chain[i+1] is the output of stage i.
  logic [WIDTH-1:0] w_chain [STAGES+1];

  assign w_chain[0] = d;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    ffd_reg_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .aclk  (aclk),
      .arstn (arstn),
      .d     (w_chain[gi]),
      .q     (w_chain[gi+1])
    );
  end

  assign q = w_chain[STAGES];

`ifdef FFD_REG_CHECK_EN
  if (STAGES < 1 || WIDTH < 1) begin : g_param_err
    $error("%s STAGES (%0d) and WIDTH (%0d) must both be >= 1",
           FFD_CHECK_PREFIX, STAGES, WIDTH);
  end

  logic [WIDTH-1:0] r_shadow [STAGES];
  logic             r_armed = 1'b0;

  // Behavioural model; only trusted once a reset edge has defined the state.
  always @(posedge aclk) begin
    if (!arstn) begin
      for (int i = 0; i < STAGES; i++) r_shadow[i] <= RESET_VAL;
      r_armed <= 1'b1;
    end else begin
      if ($isunknown(d)) begin
        $error("%s d has X/Z at rising edge: %h", FFD_CHECK_PREFIX, d);
      end
      r_shadow[0] <= d;
      for (int i = 1; i < STAGES; i++) r_shadow[i] <= r_shadow[i-1];
    end
  end

  always @(negedge aclk) begin
    if (r_armed && (q !== r_shadow[STAGES-1])) begin
      $error("%s q=%h differs from shadow=%h", FFD_CHECK_PREFIX, q,
             r_shadow[STAGES-1]);
    end
  end
`endif

endmodule

// File: tb/tb_ffd_reg.sv
// Directed bench for ffd_reg: default 1-bit/1-stage instance and an 8-bit/3-stage instance.
module tb_ffd_reg;

  logic       aclk = 1'b0;
  logic       arstn_a = 1'b0;
  logic       d_a = 1'b0;
  logic       q_a;
  logic       arstn_b = 1'b0;
  logic [7:0] d_b = 8'h00;
  logic [7:0] q_b;

  int errors = 0;
  int checks = 0;

  always #2 aclk = ~aclk;

  ffd_reg u_dut_a (
    .aclk  (aclk),
    .arstn (arstn_a),
    .d     (d_a),
    .q     (q_a)
  );

  ffd_reg #(
    .WIDTH     (8),
    .STAGES    (3),
    .RESET_VAL (8'hA5)
  ) u_dut_b (
    .aclk  (aclk),
    .arstn (arstn_b),
    .d     (d_b),
    .q     (q_b)
  );

  // Advance one rising edge, then settle 1 ns so outputs are stable.
  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic test_reset();
    arstn_a = 1'b0; d_a = 1'b0;
    arstn_b = 1'b0; d_b = 8'h00;
    #100;
    step();
    arstn_a = 1'b1;
    arstn_b = 1'b1;
    #0.5;
    checks++;
    if (q_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_q_a: got %b expected 0", q_a);
    end
    checks++;
    if (q_b !== 8'hA5) begin
      errors++;
      $display("FAIL reset_q_b: got %h expected a5", q_b);
    end
  endtask

  task automatic test_data_follow();
    logic pat [7];
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 7; i++) begin
      d_a = pat[i];
      step();
      checks++;
      if (q_a !== pat[i]) begin
        errors++;
        $display("FAIL data_follow[%0d]: got %b expected %b", i, q_a, pat[i]);
      end
    end
  endtask

  task automatic test_reset_priority();
    d_a = 1'b1;
    step();
    checks++;
    if (q_a !== 1'b1) begin
      errors++;
      $display("FAIL prio_pre: got %b expected 1", q_a);
    end
    arstn_a = 1'b0;
    step();
    checks++;
    if (q_a !== 1'b0) begin
      errors++;
      $display("FAIL prio_reset: got %b expected 0", q_a);
    end
    arstn_a = 1'b1;
    step();
    checks++;
    if (q_a !== 1'b1) begin
      errors++;
      $display("FAIL prio_release: got %b expected 1", q_a);
    end
  endtask

  task automatic test_sync_only();
    // q_a is 1 with d_a=1; pulse reset low well away from any rising edge.
    arstn_a = 1'b0;
    #1;
    arstn_a = 1'b1;
    #0.5;
    checks++;
    if (q_a !== 1'b1) begin
      errors++;
      $display("FAIL sync_pulse: got %b expected 1", q_a);
    end
    step();
    checks++;
    if (q_a !== 1'b1) begin
      errors++;
      $display("FAIL sync_next_edge: got %b expected 1", q_a);
    end
  endtask

  task automatic test_delay_line();
    logic [7:0] din [5];
    logic [7:0] qexp [5];
    din  = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    qexp = '{8'hA5, 8'hA5, 8'h01, 8'h02, 8'h03};
    arstn_b = 1'b0;
    step();
    arstn_b = 1'b1;
    for (int i = 0; i < 5; i++) begin
      d_b = din[i];
      step();
      checks++;
      if (q_b !== qexp[i]) begin
        errors++;
        $display("FAIL delay_line[%0d]: got %h expected %h", i, q_b, qexp[i]);
      end
    end
  endtask

  task automatic test_mid_stream_reset();
    logic [7:0] qexp [3];
    qexp = '{8'hA5, 8'hA5, 8'h10};
    d_b = 8'h01; step();
    d_b = 8'h02; step();
    d_b = 8'h03; step();
    checks++;
    if (q_b !== 8'h01) begin
      errors++;
      $display("FAIL mid_full: got %h expected 01", q_b);
    end
    arstn_b = 1'b0;
    d_b = 8'h77;
    step();
    checks++;
    if (q_b !== 8'hA5) begin
      errors++;
      $display("FAIL mid_reset: got %h expected a5", q_b);
    end
    arstn_b = 1'b1;
    d_b = 8'h10;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (q_b !== qexp[i]) begin
        errors++;
        $display("FAIL mid_after[%0d]: got %h expected %h", i, q_b, qexp[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_data_follow();
    test_reset_priority();
    test_sync_only();
    test_delay_line();
    test_mid_stream_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
